// File: rtl/designbench_run_ctrl_if.sv
// Handshake bundle between a benchmark harness and the run controller.
// The harness side uses the master modport, the controller the slave modport.
interface designbench_run_ctrl_if #(
    parameter int unsigned CNT_W = 64
);
    logic             start_i;
    logic             done_req_i;
    logic             finish_ready_i;
    logic             running_o;
    logic             trace_en_o;
    logic             finish_valid_o;
    logic [CNT_W-1:0] cycles_o;
    logic [1:0]       status_o;

    modport master (
        output start_i, done_req_i, finish_ready_i,
        input  running_o, trace_en_o, finish_valid_o, cycles_o, status_o
    );

    modport slave (
        input  start_i, done_req_i, finish_ready_i,
        output running_o, trace_en_o, finish_valid_o, cycles_o, status_o
    );
endinterface

// File: rtl/designbench_run_ctrl.sv
// Benchmark run controller: counts RUN cycles, ends on done request or budget
// timeout, drains, then reports cycle count and status over valid/ready.
module designbench_run_ctrl #(
    parameter int unsigned     CNT_W        = 64,
    parameter longint unsigned MAX_CYCLES   = 64'd1000000,
    parameter int unsigned     DRAIN_CYCLES = 32'd16,
    parameter longint unsigned TRACE_START  = 64'd0,
    parameter longint unsigned TRACE_STOP   = 64'd0
) (
    input  logic                  clk,
    input  logic                  rst,
    designbench_run_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    localparam int unsigned      DW         = $clog2(DRAIN_CYCLES + 32'd2);
    localparam logic [DW-1:0]    DRAIN_LAST = DW'(DRAIN_CYCLES);
    localparam logic [DW-1:0]    DRAIN_ONE  = DW'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MAX_C      = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] TS_C       = CNT_W'(TRACE_START);
    localparam logic [CNT_W-1:0] TP_C       = CNT_W'(TRACE_STOP);
    localparam bit               TIMEOUT_EN = (MAX_CYCLES != 64'd0);
    localparam bit               STOP_EN    = (TRACE_STOP != 64'd0);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [DW-1:0]    dcnt_r;
    logic [CNT_W-1:0] cycles_r;
    logic [1:0]       status_r;
    logic             running_r;
    logic             trace_r;
    logic             valid_r;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             timeout_s;

    // Trace window test on a pre-increment counter value.
    function automatic logic in_window(input logic [CNT_W-1:0] c);
        return (c >= TS_C) && (!STOP_EN || (c < TP_C));
    endfunction

    // Saturating increment: unlimited runs pin at all-ones instead of wrapping.
    always_comb begin
        cnt_inc_s = cnt_r;
        if (cnt_r == CNT_MAX) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + CNT_ONE;
        end
    end

    // Budget expiry is judged on the post-increment count so cycles_o lands on MAX_CYCLES.
    always_comb begin
        timeout_s = 1'b0;
        if (TIMEOUT_EN && (cnt_inc_s == MAX_C)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Run-control state machine with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            dcnt_r    <= {DW{1'b0}};
            cycles_r  <= CNT_ZERO;
            status_r  <= 2'd0;
            running_r <= 1'b0;
            trace_r   <= 1'b0;
            valid_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        state_r   <= ST_RUN;
                        cnt_r     <= CNT_ZERO;
                        running_r <= 1'b1;
                        trace_r   <= in_window(CNT_ZERO);
                    end
                end
                ST_RUN: begin
                    cnt_r <= cnt_inc_s;
                    if (bus.done_req_i || timeout_s) begin
                        state_r   <= ST_DRAIN;
                        cycles_r  <= cnt_inc_s;
                        status_r  <= {timeout_s, bus.done_req_i};
                        running_r <= 1'b0;
                        trace_r   <= 1'b0;
                        dcnt_r    <= {DW{1'b0}};
                    end else begin
                        trace_r <= in_window(cnt_inc_s);
                    end
                end
                ST_DRAIN: begin
                    // DRAIN always lasts DRAIN_CYCLES+1 cycles, so zero still reports next cycle.
                    if (dcnt_r == DRAIN_LAST) begin
                        state_r <= ST_REPORT;
                        valid_r <= 1'b1;
                    end else begin
                        dcnt_r <= dcnt_r + DRAIN_ONE;
                    end
                end
                ST_REPORT: begin
                    if (bus.finish_ready_i) begin
                        state_r <= ST_IDLE;
                        valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= CNT_ZERO;
                    dcnt_r    <= {DW{1'b0}};
                    cycles_r  <= CNT_ZERO;
                    status_r  <= 2'd0;
                    running_r <= 1'b0;
                    trace_r   <= 1'b0;
                    valid_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.running_o      = running_r;
    assign bus.trace_en_o     = trace_r;
    assign bus.finish_valid_o = valid_r;
    assign bus.cycles_o       = cycles_r;
    assign bus.status_o       = status_r;

endmodule

// File: tb/tb_designbench_run_ctrl.sv
// Scoreboard bench for designbench_run_ctrl: a bounded-budget instance and a
// 4-bit unlimited (saturating) instance share one transaction-level driver.
module tb_designbench_run_ctrl;

    logic clk = 1'b0;
    logic rst, sel, start, done_req, ready;

    always #5 clk = ~clk;

    designbench_run_ctrl_if #(.CNT_W(16)) ifa ();
    designbench_run_ctrl_if #(.CNT_W(4))  ifb ();

    designbench_run_ctrl #(
        .CNT_W(16), .MAX_CYCLES(64'd20), .DRAIN_CYCLES(32'd3),
        .TRACE_START(64'd3), .TRACE_STOP(64'd7)
    ) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));

    designbench_run_ctrl #(
        .CNT_W(4), .MAX_CYCLES(64'd0), .DRAIN_CYCLES(32'd0),
        .TRACE_START(64'd2), .TRACE_STOP(64'd0)
    ) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    assign ifa.start_i        = start & ~sel;
    assign ifa.done_req_i     = done_req & ~sel;
    assign ifa.finish_ready_i = ready & ~sel;
    assign ifb.start_i        = start & sel;
    assign ifb.done_req_i     = done_req & sel;
    assign ifb.finish_ready_i = ready & sel;

    logic        running, trace, fvalid;
    logic [15:0] cyc;
    logic [1:0]  st;
    assign running = sel ? ifb.running_o      : ifa.running_o;
    assign trace   = sel ? ifb.trace_en_o     : ifa.trace_en_o;
    assign fvalid  = sel ? ifb.finish_valid_o : ifa.finish_valid_o;
    assign cyc     = sel ? {12'd0, ifb.cycles_o} : ifa.cycles_o;
    assign st      = sel ? ifb.status_o       : ifa.status_o;

    // Reference model parameters for the selected instance
    int max_c, drain_c, sat_c, ts_c, tp_c;

    typedef struct { int cyc; int st; } exp_t;
    exp_t sb[$];
    int n_vec = 0;
    int n_err = 0;
    int last_cyc = 0;
    int last_st  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic use_dut(input bit s);
        sel = s;
        if (s) begin
            max_c = 0;  drain_c = 0; sat_c = 15;    ts_c = 2; tp_c = 0;
        end else begin
            max_c = 20; drain_c = 3; sat_c = 65535; ts_c = 3; tp_c = 7;
        end
    endtask

    function automatic bit win(input int c);
        return (c >= ts_c) && (tp_c == 0 || c < tp_c);
    endfunction

    // Monitor: every cycle the result is valid it must match the head; pop on handshake.
    always @(negedge clk) begin
        #2;
        if (!rst && fvalid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got valid with cycles %0d status %0d, expected none", cyc, st);
            end else begin
                chk("result_cycles", int'(cyc), sb[0].cyc);
                chk("result_status", int'(st), sb[0].st);
                if (ready) void'(sb.pop_front());
            end
        end
    end

    // One full run: start, RUN cycles, DRAIN, REPORT with optional backpressure.
    task automatic do_run(input int done_at, input int delay, input bit junk);
        int L, ec, es;
        if (done_at != 0 && (max_c == 0 || done_at < max_c)) begin
            L = done_at; es = 1;
        end else if (done_at != 0 && done_at == max_c) begin
            L = done_at; es = 3;
        end else begin
            L = max_c; es = 2;
        end
        ec = (L > sat_c) ? sat_c : L;
        sb.push_back('{ec, es});
        last_cyc = ec;
        last_st  = es;

        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 1; k <= L; k++) begin
            done_req = (k == done_at);
            start    = junk && (k == 2);
            ready    = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            chk("running_run", int'(running), 1);
            chk("trace_run", int'(trace), int'(win((k - 1 > sat_c) ? sat_c : k - 1)));
            @(negedge clk);
        end
        start = 1'b0;
        ready = 1'b0;
        for (int d = 0; d <= drain_c; d++) begin
            chk("running_drain", int'(running), 0);
            chk("trace_drain", int'(trace), 0);
            chk("valid_early", int'(fvalid), 0);
            done_req = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            ready    = (d == drain_c) && (delay == 0);
            @(negedge clk);
        end
        done_req = 1'b0;
        for (int r = 0; r < delay; r++) begin
            chk("valid_held", int'(fvalid), 1);
            start = junk && (r == 0);
            @(negedge clk);
        end
        start = 1'b0;
        ready = 1'b1;
        chk("valid_rise", int'(fvalid), 1);
        @(negedge clk);
        ready = 1'b0;
        chk("valid_drop", int'(fvalid), 0);
        chk("running_idle", int'(running), 0);
        chk("cycles_hold", int'(cyc), last_cyc);
        chk("status_hold", int'(st), last_st);
    endtask

    // Reset asserted during DRAIN drops the pending result without a handshake.
    task automatic abort_run();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            done_req = (k == 5);
            @(negedge clk);
        end
        done_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_running", int'(running), 0);
        chk("abort_trace", int'(trace), 0);
        chk("abort_valid", int'(fvalid), 0);
        chk("abort_cycles", int'(cyc), 0);
        chk("abort_status", int'(st), 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_no_report", int'(fvalid), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; done_req = 1'b0; ready = 1'b0;
        use_dut(1'b0);
        repeat (2) @(negedge clk);
        chk("rst_a_running", int'(ifa.running_o), 0);
        chk("rst_a_trace",   int'(ifa.trace_en_o), 0);
        chk("rst_a_valid",   int'(ifa.finish_valid_o), 0);
        chk("rst_a_cycles",  int'(ifa.cycles_o), 0);
        chk("rst_a_status",  int'(ifa.status_o), 0);
        chk("rst_b_running", int'(ifb.running_o), 0);
        chk("rst_b_valid",   int'(ifb.finish_valid_o), 0);
        chk("rst_b_cycles",  int'(ifb.cycles_o), 0);
        rst = 1'b0;

        do_run(10, 0, 1'b0);
        do_run(0, 2, 1'b1);
        do_run(20, 5, 1'b0);
        do_run(1, 1, 1'b1);
        do_run(25, 0, 1'b1);
        abort_run();
        do_run(7, 1, 1'b0);
        repeat (20) do_run(int'($urandom_range(0, 25)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));

        @(negedge clk);
        use_dut(1'b1);
        do_run(20, 0, 1'b0);
        do_run(3, 2, 1'b1);
        do_run(15, 0, 1'b0);
        do_run(16, 1, 1'b1);
        repeat (8) do_run(int'($urandom_range(1, 30)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/designbench_run_ctrl.md
Name: designbench_run_ctrl

Overview:
Synthesizable run controller for benchmark harnesses. It sits in the main clock domain beside the DUT and counts cycles from run start. It ends the run on a DUT completion request or on a cycle-budget timeout, waits a fixed drain period, then presents the final cycle count and status over a valid/ready handshake. It also generates a cycle-windowed waveform-trace enable.

Parameters:
CNT_W, 64, width of cycle counter and cycles_o.
MAX_CYCLES, 1000000, cycle budget measured from run start; 0 = unlimited (no timeout).
DRAIN_CYCLES, 16, cycles spent in DRAIN before reporting; 0 = report on the next cycle.
TRACE_START, 0, cycle count at which trace_en_o rises.
TRACE_STOP, 0, cycle count at which trace_en_o falls; 0 = never falls during RUN.

Ports:
clk  in  1  main benchmark clock
rst  in  1  synchronous, active-high reset
start_i  in  1  single-cycle run start request; honoured only in IDLE
done_req_i  in  1  DUT completion request; sampled only in RUN
finish_ready_i  in  1  harness accepts the result
running_o  out  1  high while in RUN
trace_en_o  out  1  waveform trace window enable
finish_valid_o  out  1  result valid; held until accepted
cycles_o  out  CNT_W  final cycle count; stable while finish_valid_o is high
status_o  out  2  result status: 0 none, 1 done, 2 timeout, 3 done and timeout in the same cycle

Behaviour:
- Reset: on rst high at a clk edge, state=IDLE, counter=0, and every output is 0, including status_o.
- States and transitions:
  - IDLE -> RUN on start_i. The counter clears to 0 in the same edge.
  - RUN: the counter increments by 1 on every edge.
    - done_req_i=1 -> DRAIN with status 1.
    - Counter+1 == MAX_CYCLES (MAX_CYCLES != 0) -> DRAIN with status 2.
    - Both in the same cycle -> status 3.
  - DRAIN: the counter freezes at the value latched on RUN exit. A separate drain counter runs DRAIN_CYCLES cycles, then the block moves to REPORT.
  - REPORT: finish_valid_o=1. On finish_valid_o && finish_ready_i the block moves to IDLE the next edge, and finish_valid_o drops.
- cycles_o = number of RUN-state edges, including the exiting edge.
  - Done request seen on the first RUN cycle -> cycles_o=1.
  - Timeout -> cycles_o=MAX_CYCLES exactly.
- Output timing:
  - cycles_o and status_o update only on RUN exit.
  - Both hold their values through DRAIN, REPORT and the following IDLE, until the next start_i.
- Ignored inputs:
  - start_i outside IDLE is ignored, not queued.
  - done_req_i outside RUN is ignored.
  - finish_ready_i outside REPORT is ignored.
  - finish_ready_i high on entry to REPORT gives a one-cycle finish_valid_o pulse.
- trace_en_o is registered and is 1 only while state=RUN and the window condition holds.
  - Window condition: counter >= TRACE_START and (TRACE_STOP==0 or counter < TRACE_STOP).
  - "counter" here is the pre-increment value of that cycle.
  - TRACE_STOP <= TRACE_START, with TRACE_STOP != 0, means trace_en_o is never 1.
  - trace_en_o falls on the edge of RUN exit.
- running_o is registered and equals (state==RUN).
- Counter wrap: in unlimited mode the counter saturates at all-ones rather than wrapping. A saturated cycles_o is all-ones.
- Reset mid-run: reset from any state returns to IDLE and clears all outputs. A pending finish_valid_o is dropped without a handshake.

Test Plan:
- Done path: rst 2 cycles; start_i pulse; done_req_i on the 10th RUN cycle; DRAIN_CYCLES=16 -> running_o high for 10 cycles; finish_valid_o rises 17 edges after RUN exit; cycles_o=10; status_o=1.
- Timeout: MAX_CYCLES=50, done_req_i never asserted -> cycles_o=50, status_o=2; done_req_i asserted during DRAIN has no effect.
- Simultaneous exit and backpressure: MAX_CYCLES=20, done_req_i on RUN cycle 20 -> status_o=3. Then hold finish_ready_i low for 5 REPORT cycles -> finish_valid_o, cycles_o and status_o stay stable; ready high -> IDLE next edge.
- Trace window: TRACE_START=3, TRACE_STOP=7, run 12 cycles -> trace_en_o high for exactly 4 cycles, covering counter values 3..6.
- Ignored start and reset abort: start_i pulsed during RUN and again during REPORT -> no restart. rst asserted while in DRAIN -> all outputs 0 next edge; a new start_i begins a fresh count from 0.
- Saturation: CNT_W=4, MAX_CYCLES=0, run 20 cycles then done_req_i -> cycles_o=15, status_o=1.
